apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB completer (slave) end of the bus: a word-addressed 32-bit register file selected by one PSELx line from the master bridge.
- Accepts single read/write transfers (setup then access phase) with a programmable number of wait states.
- Flags out-of-range or misaligned addresses with pslverr.
- Two instances (on PSEL1 and PSEL2) form the slave side of the bus.

Parameters:
- DEPTH, 16: number of 32-bit registers; power of 2, range 2..256.
- ADDR_BASE, 32'h0000_0000: byte address of register 0; DEPTH*4-aligned.
- WAIT_CYCLES, 0: wait states inserted before pready; range 0..15.

Ports:
- pclk  in  1  bus clock; all state updates on its rising edge.
- Reset_n  in  1  reset, synchronous, active-low.
- psel  in  1  slave select (PSEL1 or PSEL2 from the bridge).
- penable  in  1  access-phase strobe.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  32  byte address.
- pwdata  in  32  write data.
- prdata  out  32  read data; valid only while pready=1 on a read.
- pready  out  1  transfer-complete strobe.
- pslverr  out  1  error response; valid only while pready=1.

Behaviour:
- Reset (Reset_n=0 at a pclk edge):
  - state=IDLE; pready=0, pslverr=0, prdata=0.
  - All DEPTH registers cleared to 0; wait counter cleared.
  - Reset overrides any transfer in progress. The aborted write is not committed.
- All outputs are registered. There is no combinational path from input to output.
- FSM has 3 states: IDLE, WAIT, READY.
- IDLE:
  - On psel=1 and penable=0 (setup phase), latch pwrite, paddr and pwdata. Compute err = (paddr[1:0]!=0) or paddr outside [ADDR_BASE, ADDR_BASE+4*DEPTH-1].
  - If WAIT_CYCLES=0: go to READY, and load pready=1 and pslverr=err at the same edge, so pready is high in the first access cycle (zero-wait).
  - Otherwise: load counter=WAIT_CYCLES-1 and go to WAIT.
  - penable=1 seen in IDLE (protocol violation) is ignored; stay in IDLE.
- WAIT:
  - pready=0.
  - If psel=0: abort to IDLE, no side effects.
  - Else if counter=0: go to READY and set pready=1, pslverr=err.
  - Else decrement counter.
  - Result: pready rises exactly WAIT_CYCLES cycles after the first access cycle.
- READY (pready=1):
  - On psel=1 and penable=1 at the edge, the transfer completes.
    - Write with err=0: reg[idx] <= latched pwdata.
    - Then go to IDLE with pready=0, pslverr=0, prdata=0.
  - If psel=0: abort to IDLE, no write.
  - If psel=1 and penable=0: treat as abort plus a new setup, re-running the IDLE setup logic in that cycle.
- Index and write rules:
  - idx = (latched paddr - ADDR_BASE) >> 2, truncated to log2(DEPTH) bits.
  - A write with err=1 is discarded.
- Read data:
  - prdata is loaded at the edge that raises pready: reg[idx] if err=0, else 32'h0.
  - prdata is 0 whenever pready=0.
  - It reflects register contents at that edge; a write completing in the same cycle cannot occur, since there is a single transfer in flight.
- Latched values: paddr, pwdata and pwrite changes during the access phase are ignored.
- Back-to-back: the bridge returns to setup the cycle after completion. IDLE accepts that setup immediately, giving no dead cycle beyond the APB setup phase.

Decomposition:
- Shared package apb_pkg holds:
  - state encoding localparams ST_IDLE=2'b00, ST_WAIT=2'b01, ST_READY=2'b10;
  - APB_DATA_W=32 and APB_ADDR_W=32;
  - err-response constant RDATA_ERR=32'h0.
- One natural sub-module, apb_regfile_mem: DEPTH x 32 array with a synchronous write port, one read port and synchronous clear.
- FSM, counter and error decode stay in the top.

Test Plan:
- Reset then zero-wait write/read (WAIT_CYCLES=0):
  - Write 32'hDEAD_BEEF to ADDR_BASE+8 → pready=1 in the first access cycle, pslverr=0.
  - Read ADDR_BASE+8 → prdata=32'hDEAD_BEEF with pready=1 in the first access cycle.
- Wait states (WAIT_CYCLES=3):
  - Read any address → pready stays 0 for 3 access cycles and rises in the 4th; prdata=0 before that.
  - Write latency matches the read latency.
- Error response:
  - Write 32'h1234_5678 to ADDR_BASE+4*DEPTH → pready=1, pslverr=1; a later read of reg[0] still returns its prior value.
  - Read ADDR_BASE+2 (misaligned) → pslverr=1, prdata=0.
- Abort: with WAIT_CYCLES=2, write 32'hA5A5_A5A5, drop psel during WAIT → FSM returns to IDLE, pready never rises, the register keeps its old value.
- Back-to-back: write reg 1 = 32'h1, then immediately a setup reading reg 1 → completes with prdata=32'h1 and no extra idle cycle.
- Reset mid-transfer: assert Reset_n=0 in READY of a write → pready=0 next cycle, the write is not committed, all registers read back 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, bus widths and the error read value.
package apb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WAIT  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;

    localparam logic [APB_DATA_W-1:0] RDATA_ERR = 32'h0;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_WAIT  = ST_WAIT,
        S_READY = ST_READY
    } state_t;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus between the bridge (master) and one completer (slave) selected by psel.
interface apb_slave_regfile_if;
    import apb_pkg::*;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [APB_ADDR_W-1:0] paddr;
    logic [APB_DATA_W-1:0] pwdata;
    logic [APB_DATA_W-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_regfile_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port,
// synchronous clear that takes priority over the write.
module apb_regfile_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = apb_pkg::APB_DATA_W,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_idx] <= wdata;
        end
    end

    assign rdata = mem[rd_idx];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer fronting a word-addressed register file, with programmable wait states
// and pslverr on misaligned or out-of-window addresses. All bus outputs are registered.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                    DEPTH       = 16,
    parameter logic [APB_ADDR_W-1:0] ADDR_BASE   = 32'h0000_0000,
    parameter int                    WAIT_CYCLES = 0
) (
    input logic                pclk,
    input logic                Reset_n,
    apb_slave_regfile_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  wr_lat, wr_lat_n;
    logic                  err_lat, err_lat_n;
    logic [IDX_W-1:0]      idx_lat, idx_lat_n;
    logic [APB_DATA_W-1:0] wdata_lat, wdata_lat_n;
    logic                  pready_r, pready_n;
    logic                  pslverr_r, pslverr_n;
    logic [APB_DATA_W-1:0] prdata_r, prdata_n;

    logic                  we;
    logic [IDX_W-1:0]      rd_idx;
    logic [APB_DATA_W-1:0] rd_data;
    logic [APB_ADDR_W-1:0] offset;
    logic                  err_setup;
    logic                  do_setup;

    // Unsigned wrap makes addresses below ADDR_BASE land far outside the window.
    assign offset    = bus.paddr - ADDR_BASE;
    assign err_setup = (offset[1:0] != 2'b00) || (offset[APB_ADDR_W-1:IDX_W+2] != '0);
    assign do_setup  = bus.psel && !bus.penable && (state == S_IDLE || state == S_READY);
    assign rd_idx    = do_setup ? offset[IDX_W+1:2] : idx_lat;

    apb_regfile_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (APB_DATA_W)
    ) u_mem (
        .clk    (pclk),
        .clr    (!Reset_n),
        .we     (we),
        .wr_idx (idx_lat),
        .wdata  (wdata_lat),
        .rd_idx (rd_idx),
        .rdata  (rd_data)
    );

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        wr_lat_n    = wr_lat;
        err_lat_n   = err_lat;
        idx_lat_n   = idx_lat;
        wdata_lat_n = wdata_lat;
        pready_n    = 1'b0;
        pslverr_n   = 1'b0;
        prdata_n    = '0;
        we          = 1'b0;

        case (state)
            S_IDLE: ;
            S_WAIT: begin
                if (!bus.psel) begin
                    state_n = S_IDLE;
                end else if (cnt == '0) begin
                    state_n   = S_READY;
                    pready_n  = 1'b1;
                    pslverr_n = err_lat;
                    prdata_n  = err_lat ? RDATA_ERR : rd_data;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_READY: begin
                state_n = S_IDLE;
                if (bus.psel && bus.penable) begin
                    we = wr_lat && !err_lat;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // A setup phase in IDLE, or one arriving instead of completion in READY, starts a new transfer.
        if (do_setup) begin
            wr_lat_n    = bus.pwrite;
            err_lat_n   = err_setup;
            idx_lat_n   = offset[IDX_W+1:2];
            wdata_lat_n = bus.pwdata;
            if (WAIT_CYCLES == 0) begin
                state_n   = S_READY;
                pready_n  = 1'b1;
                pslverr_n = err_setup;
                prdata_n  = err_setup ? RDATA_ERR : rd_data;
            end else begin
                state_n = S_WAIT;
                cnt_n   = CNT_W'(WAIT_CYCLES - 1);
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wr_lat    <= 1'b0;
            err_lat   <= 1'b0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            wr_lat    <= wr_lat_n;
            err_lat   <= err_lat_n;
            pready_r  <= pready_n;
            pslverr_r <= pslverr_n;
            prdata_r  <= prdata_n;
        end
    end

    always_ff @(posedge pclk) begin
        idx_lat   <= idx_lat_n;
        wdata_lat <= wdata_lat_n;
    end

    assign bus.pready  = pready_r;
    assign bus.pslverr = pslverr_r;
    assign bus.prdata  = prdata_r;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: three completers on one bus (zero-wait, 3-wait, 2-wait with a non-zero base).
module tb_apb_slave_regfile;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  psel_v = 3'b000;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = 32'h0;
    logic [31:0] pwdata = 32'h0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cur = 0;

    logic [31:0] prdata_m;
    logic        pready_m;
    logic        pslverr_m;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    apb_slave_regfile_if bus0();
    apb_slave_regfile_if bus1();
    apb_slave_regfile_if bus2();

    assign bus0.psel = psel_v[0];
    assign bus1.psel = psel_v[1];
    assign bus2.psel = psel_v[2];
    assign bus0.penable = penable;
    assign bus1.penable = penable;
    assign bus2.penable = penable;
    assign bus0.pwrite = pwrite;
    assign bus1.pwrite = pwrite;
    assign bus2.pwrite = pwrite;
    assign bus0.paddr = paddr;
    assign bus1.paddr = paddr;
    assign bus2.paddr = paddr;
    assign bus0.pwdata = pwdata;
    assign bus1.pwdata = pwdata;
    assign bus2.pwdata = pwdata;

    apb_slave_regfile #(.DEPTH(16), .ADDR_BASE(32'h0000_0000), .WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .Reset_n(rst_n), .bus(bus0));
    apb_slave_regfile #(.DEPTH(8), .ADDR_BASE(32'h0000_0000), .WAIT_CYCLES(3)) dut1 (
        .pclk(pclk), .Reset_n(rst_n), .bus(bus1));
    apb_slave_regfile #(.DEPTH(16), .ADDR_BASE(32'h0000_1000), .WAIT_CYCLES(2)) dut2 (
        .pclk(pclk), .Reset_n(rst_n), .bus(bus2));

    always_comb begin
        case (cur)
            1:       begin prdata_m = bus1.prdata; pready_m = bus1.pready; pslverr_m = bus1.pslverr; end
            2:       begin prdata_m = bus2.prdata; pready_m = bus2.pready; pslverr_m = bus2.pslverr; end
            default: begin prdata_m = bus0.prdata; pready_m = bus0.pready; pslverr_m = bus0.pslverr; end
        endcase
    end

    // Full transfer; returns after the completion edge so a following call is back-to-back.
    task automatic apb_xfer(input int tgt, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, output logic [31:0] rdata,
                            output logic err, output int waits);
        cur = tgt;
        psel_v = 3'b000;
        psel_v[tgt] = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = addr;
        pwdata = data;
        @(posedge pclk); #1;
        penable = 1'b1;
        paddr = ~addr;
        pwdata = ~data;
        pwrite = ~wr;
        waits = 0;
        while (pready_m !== 1'b1 && waits < 40) begin
            checks++;
            if (prdata_m !== 32'h0) begin
                errors++;
                $display("FAIL prdata_while_waiting: got %h expected 00000000", prdata_m);
            end
            @(posedge pclk); #1;
            waits++;
        end
        checks++;
        if (pready_m !== 1'b1) begin
            errors++;
            $display("FAIL pready_timeout: pready=%b after %0d cycles, expected 1", pready_m, waits);
        end
        rdata = prdata_m;
        err = pslverr_m;
        @(posedge pclk); #1;
    endtask

    task automatic bus_idle();
        psel_v = 3'b000;
        penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        for (int t = 0; t < 3; t++) begin
            cur = t;
            #0;
            checks++;
            if (pready_m !== 1'b0 || pslverr_m !== 1'b0 || prdata_m !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got pready=%b pslverr=%b prdata=%h expected 0/0/0",
                         t, pready_m, pslverr_m, prdata_m);
            end
        end
        rst_n = 1'b1;
        @(posedge pclk); #1;
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd;
        logic        err;
        int          w;
        apb_xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF, rd, err, w);
        checks++;
        if (w !== 0 || err !== 1'b0) begin
            errors++;
            $display("FAIL zw_write: got waits=%0d pslverr=%b expected 0/0", w, err);
        end
        bus_idle();
        apb_xfer(0, 1'b0, 32'h8, 32'h0, rd, err, w);
        checks++;
        if (w !== 0 || err !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL zw_read: got waits=%0d pslverr=%b prdata=%h expected 0/0/deadbeef", w, err, rd);
        end
        bus_idle();
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic        err;
        int          w;
        apb_xfer(1, 1'b0, 32'h8, 32'h0, rd, err, w);
        checks++;
        if (w !== 3 || rd !== 32'h0) begin
            errors++;
            $display("FAIL ws_read_reset_reg: got waits=%0d prdata=%h expected 3/00000000", w, rd);
        end
        bus_idle();
        apb_xfer(1, 1'b1, 32'h10, 32'hCAFE_0001, rd, err, w);
        checks++;
        if (w !== 3 || err !== 1'b0) begin
            errors++;
            $display("FAIL ws_write: got waits=%0d pslverr=%b expected 3/0", w, err);
        end
        bus_idle();
        apb_xfer(1, 1'b0, 32'h10, 32'h0, rd, err, w);
        checks++;
        if (w !== 3 || rd !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL ws_readback: got waits=%0d prdata=%h expected 3/cafe0001", w, rd);
        end
        bus_idle();
    endtask

    task automatic test_error();
        logic [31:0] rd;
        logic        err;
        int          w;
        apb_xfer(0, 1'b1, 32'h0, 32'h1111_0000, rd, err, w);
        bus_idle();
        apb_xfer(0, 1'b1, 32'h40, 32'h1234_5678, rd, err, w);
        checks++;
        if (w !== 0 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_oob_write: got waits=%0d pslverr=%b expected 0/1", w, err);
        end
        bus_idle();
        apb_xfer(0, 1'b0, 32'h0, 32'h0, rd, err, w);
        checks++;
        if (err !== 1'b0 || rd !== 32'h1111_0000) begin
            errors++;
            $display("FAIL err_reg0_kept: got pslverr=%b prdata=%h expected 0/11110000", err, rd);
        end
        bus_idle();
        apb_xfer(0, 1'b0, 32'h2, 32'h0, rd, err, w);
        checks++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_misaligned: got pslverr=%b prdata=%h expected 1/00000000", err, rd);
        end
        bus_idle();
        apb_xfer(0, 1'b0, 32'h3C, 32'h0, rd, err, w);
        checks++;
        if (err !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_top_reg: got pslverr=%b prdata=%h expected 0/00000000", err, rd);
        end
        bus_idle();
        apb_xfer(2, 1'b0, 32'h0FFC, 32'h0, rd, err, w);
        checks++;
        if (err !== 1'b1 || w !== 2) begin
            errors++;
            $display("FAIL err_below_base: got pslverr=%b waits=%0d expected 1/2", err, w);
        end
        bus_idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        logic        err;
        int          w;
        apb_xfer(2, 1'b1, 32'h1004, 32'h0BAD_0001, rd, err, w);
        checks++;
        if (w !== 2 || err !== 1'b0) begin
            errors++;
            $display("FAIL abort_prewrite: got waits=%0d pslverr=%b expected 2/0", w, err);
        end
        bus_idle();
        cur = 2;
        psel_v = 3'b100;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h1004;
        pwdata = 32'hA5A5_A5A5;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel_v = 3'b000;
        penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            checks++;
            if (pready_m !== 1'b0) begin
                errors++;
                $display("FAIL abort_pready_cycle%0d: got %b expected 0", i, pready_m);
            end
        end
        apb_xfer(2, 1'b0, 32'h1004, 32'h0, rd, err, w);
        checks++;
        if (rd !== 32'h0BAD_0001 || w !== 2) begin
            errors++;
            $display("FAIL abort_reg_kept: got prdata=%h waits=%0d expected 0bad0001/2", rd, w);
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        err;
        int          w;
        int          c0;
        c0 = cyc;
        apb_xfer(0, 1'b1, 32'h4, 32'h1, rd, err, w);
        apb_xfer(0, 1'b0, 32'h4, 32'h0, rd, err, w);
        checks++;
        if (rd !== 32'h1 || w !== 0) begin
            errors++;
            $display("FAIL b2b_read: got prdata=%h waits=%0d expected 00000001/0", rd, w);
        end
        checks++;
        if (cyc - c0 !== 4) begin
            errors++;
            $display("FAIL b2b_cycles: got %0d expected 4", cyc - c0);
        end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        err;
        int          w;
        cur = 0;
        psel_v = 3'b001;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'hC;
        pwdata = 32'h7777_7777;
        @(posedge pclk); #1;
        penable = 1'b1;
        checks++;
        if (pready_m !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready: got pready=%b expected 1", pready_m);
        end
        rst_n = 1'b0;
        @(posedge pclk); #1;
        checks++;
        if (pready_m !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pready: got %b expected 0", pready_m);
        end
        rst_n = 1'b1;
        psel_v = 3'b000;
        penable = 1'b0;
        @(posedge pclk); #1;
        apb_xfer(0, 1'b0, 32'hC, 32'h0, rd, err, w);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_not_committed: got %h expected 00000000", rd);
        end
        bus_idle();
        apb_xfer(0, 1'b0, 32'h8, 32'h0, rd, err, w);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_cleared_reg2: got %h expected 00000000", rd);
        end
        bus_idle();
        apb_xfer(0, 1'b0, 32'h0, 32'h0, rd, err, w);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_cleared_reg0: got %h expected 00000000", rd);
        end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_error();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
